// File: rtl/tile_spawner.sv
// Tile spawner: 7-bag randomizer with a one-deep preview that feeds
// the tile executor through a single-cycle valid pulse.
package tile_spawner_pkg;
  typedef enum logic [2:0] {
    eNon = 3'd0,
    eI   = 3'd1,
    eJ   = 3'd2,
    eL   = 3'd3,
    eO   = 3'd4,
    eS   = 3'd5,
    eT   = 3'd6,
    eZ   = 3'd7
  } tile_type_e;
endpackage

module tile_spawner
  import tile_spawner_pkg::*;
#(
  parameter logic [15:0] seed_p         = 16'hACE1,
  parameter bit          random_angle_p = 1'b0,
  parameter int unsigned fallback_p     = 8
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       start_i,
  input  logic       halt_i,
  input  logic       done_i,
  output tile_type_e tile_type_o,
  output logic [1:0] tile_type_angle_o,
  output logic       v_o,
  output tile_type_e next_tile_type_o,
  output logic       busy_o,
  output logic [15:0] tile_count_o
);

  localparam int RW =
    (fallback_p < 1) ? 1 : $clog2(fallback_p + 1);

  typedef enum logic [2:0] {
    eIDLE,
    eDraw,
    eIssue,
    eWait,
    eHalt
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [6:0]  bag_q, bag_d;
  logic [RW-1:0] rej_q, rej_d;
  logic        nv_q, nv_d;
  tile_type_e  prev_q, prev_d;
  tile_type_e  cur_q, cur_d;
  logic [1:0]  ang_q, ang_d;
  logic [15:0] cnt_q, cnt_d;

  logic [2:0]  cand;
  logic [7:0]  bag_ext;
  logic        hit;
  logic        forced;
  logic        take;
  logic [2:0]  low_idx;
  logic [2:0]  pick;
  logic [6:0]  bag_clr;
  logic [6:0]  bag_nx;
  tile_type_e  new_tile;

  // Galois form of x^16+x^14+x^13+x^11+1
  assign lfsr_d = lfsr_q[0]
                ? ((lfsr_q >> 1) ^ 16'hB400)
                : (lfsr_q >> 1);

  assign cand    = lfsr_q[2:0];
  assign bag_ext = {1'b0, bag_q};
  assign hit     = bag_ext[cand];
  assign forced  = (rej_q == RW'(fallback_p));
  assign take    = hit | forced;

  always_comb begin
    low_idx = 3'd0;
    for (int k = 6; k >= 0; k--) begin
      if (bag_q[k]) low_idx = 3'(k);
    end
  end

  assign pick     = hit ? cand : low_idx;
  assign bag_clr  = bag_q & ~(7'd1 << pick);
  assign bag_nx   = (bag_clr == 7'd0) ? 7'h7F : bag_clr;
  assign new_tile = tile_type_e'(pick + 3'd1);

  always_comb begin
    state_d = state_q;
    bag_d   = bag_q;
    rej_d   = rej_q;
    nv_d    = nv_q;
    prev_d  = prev_q;
    cur_d   = cur_q;
    ang_d   = ang_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      eIDLE, eHalt: begin
        if (start_i) begin
          state_d = eDraw;
          bag_d   = 7'h7F;
          nv_d    = 1'b0;
          cnt_d   = 16'd0;
          rej_d   = '0;
        end
      end
      eDraw: begin
        if (halt_i) begin
          state_d = eHalt;
        end else if (take) begin
          bag_d = bag_nx;
          rej_d = '0;
          if (!nv_q) begin
            prev_d = new_tile;
            nv_d   = 1'b1;
          end else begin
            cur_d   = prev_q;
            prev_d  = new_tile;
            ang_d   = random_angle_p ? lfsr_q[9:8] : 2'd0;
            state_d = eIssue;
          end
        end else begin
          rej_d = rej_q + 1'b1;
        end
      end
      eIssue: begin
        cnt_d   = cnt_q + 16'd1;
        state_d = halt_i ? eHalt : eWait;
      end
      eWait: begin
        if (halt_i) state_d = eHalt;
        else if (done_i) state_d = eDraw;
      end
      default: state_d = eIDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= eIDLE;
      lfsr_q  <= seed_p;
      bag_q   <= 7'h7F;
      rej_q   <= '0;
      nv_q    <= 1'b0;
      prev_q  <= eNon;
      cur_q   <= eNon;
      ang_q   <= 2'd0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      bag_q   <= bag_d;
      rej_q   <= rej_d;
      nv_q    <= nv_d;
      prev_q  <= prev_d;
      cur_q   <= cur_d;
      ang_q   <= ang_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tile_type_o       = cur_q;
  assign tile_type_angle_o = ang_q;
  assign v_o               = (state_q == eIssue);
  assign next_tile_type_o  = nv_q ? prev_q : eNon;
  assign busy_o            = (state_q == eDraw)
                          || (state_q == eIssue)
                          || (state_q == eWait);
  assign tile_count_o      = cnt_q;

endmodule

// File: tb/tb_tile_spawner.sv
// Randomized bench for tile_spawner: two instances (fixed and random
// angle) checked each cycle against a behavioural bag/preview model.
module tb_tile_spawner;

  localparam int FB = 8;
  localparam int P_IDLE  = 0;
  localparam int P_DRAW  = 1;
  localparam int P_ISSUE = 2;
  localparam int P_WAIT  = 3;
  localparam int P_HALT  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, halt, done;
  logic [2:0]  t0, n0, t1, n1;
  logic [1:0]  a0, a1;
  logic        v0, v1, b0, b1;
  logic [15:0] c0, c1;

  int n_chk  = 0;
  int n_fail = 0;

  tile_spawner #(
    .seed_p(16'hACE1), .random_angle_p(1'b0), .fallback_p(FB)
  ) dut0 (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start),
    .halt_i(halt), .done_i(done), .tile_type_o(t0),
    .tile_type_angle_o(a0), .v_o(v0), .next_tile_type_o(n0),
    .busy_o(b0), .tile_count_o(c0)
  );

  tile_spawner #(
    .seed_p(16'hACE1), .random_angle_p(1'b1), .fallback_p(FB)
  ) dut1 (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start),
    .halt_i(halt), .done_i(done), .tile_type_o(t1),
    .tile_type_angle_o(a1), .v_o(v1), .next_tile_type_o(n1),
    .busy_o(b1), .tile_count_o(c1)
  );

  // behavioural model
  int          m_phase;
  logic [15:0] m_lfsr;
  bit          m_avail [7];
  int          m_rej;
  bit          m_nv;
  int          m_prev, m_cur, m_ang, m_cnt;
  int          m_forced = 0;

  function automatic logic [15:0] adv(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE;
    m_lfsr  = 16'hACE1;
    foreach (m_avail[k]) m_avail[k] = 1'b1;
    m_rej  = 0;
    m_nv   = 1'b0;
    m_prev = 0;
    m_cur  = 0;
    m_ang  = 0;
    m_cnt  = 0;
  endtask

  task automatic model_draw(input logic [15:0] s);
    int cand;
    int pick;
    int left;
    cand = int'(s[2:0]);
    pick = -1;
    if (cand < 7 && m_avail[cand]) begin
      pick = cand;
    end else if (m_rej == FB) begin
      for (int k = 6; k >= 0; k--) if (m_avail[k]) pick = k;
      m_forced++;
    end else begin
      m_rej++;
    end
    if (pick >= 0) begin
      m_avail[pick] = 1'b0;
      left = 0;
      foreach (m_avail[k]) left += int'(m_avail[k]);
      if (left == 0) foreach (m_avail[k]) m_avail[k] = 1'b1;
      m_rej = 0;
      if (!m_nv) begin
        m_prev = pick + 1;
        m_nv   = 1'b1;
      end else begin
        m_cur   = m_prev;
        m_prev  = pick + 1;
        m_ang   = int'(s[9:8]);
        m_phase = P_ISSUE;
      end
    end
  endtask

  task automatic model_step();
    logic [15:0] s;
    if (!rst_n) begin
      model_reset();
    end else begin
      s = m_lfsr;
      case (m_phase)
        P_IDLE, P_HALT: if (start) begin
          foreach (m_avail[k]) m_avail[k] = 1'b1;
          m_nv = 1'b0; m_cnt = 0; m_rej = 0;
          m_phase = P_DRAW;
        end
        P_DRAW: begin
          if (halt) m_phase = P_HALT;
          else model_draw(s);
        end
        P_ISSUE: begin
          m_cnt   = (m_cnt + 1) % 65536;
          m_phase = halt ? P_HALT : P_WAIT;
        end
        default: begin
          if (halt) m_phase = P_HALT;
          else if (done) m_phase = P_DRAW;
        end
      endcase
      m_lfsr = adv(s);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    chk("tile0", 32'(t0), 32'(m_cur));
    chk("tile1", 32'(t1), 32'(m_cur));
    chk("angle0", 32'(a0), 32'd0);
    chk("angle1", 32'(a1), 32'(m_ang));
    chk("v0", 32'(v0), 32'(m_phase == P_ISSUE));
    chk("v1", 32'(v1), 32'(m_phase == P_ISSUE));
    chk("next0", 32'(n0), m_nv ? 32'(m_prev) : 32'd0);
    chk("next1", 32'(n1), m_nv ? 32'(m_prev) : 32'd0);
    chk("busy0", 32'(b0),
        32'(m_phase >= P_DRAW && m_phase <= P_WAIT));
    chk("count0", 32'(c0), 32'(m_cnt));
    chk("count1", 32'(c1), 32'(m_cnt));
  end

  logic [3:0] ang_seen = 4'h0;
  int         iss [$];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (v1) ang_seen = ang_seen | (4'h1 << a1);
  endtask

  task automatic wait_v(output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < FB + 4; i++) begin
      tick();
      cyc++;
      if (v0) begin
        ok = 1'b1;
        return;
      end
    end
    chk("v_timeout", 32'd0, 32'd1);
  endtask

  // lfsr at the start edge is ACE1>>>2 = 7138; draws see 389C, 1C4E
  task automatic seed_start();
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("lit_busy_after_start", 32'(b0), 32'd1);
    chk("lit_next_after_start", 32'(n0), 32'd0);
    tick();
    chk("lit_preview", 32'(n0), 32'd5);
    chk("lit_no_v_yet", 32'(v0), 32'd0);
    tick();
    chk("lit_v_cycle3", 32'(v0), 32'd1);
    chk("lit_tile", 32'(t0), 32'd5);
    chk("lit_next", 32'(n0), 32'd7);
    chk("lit_angle1", 32'(a1), 32'd0);
    iss.push_back(int'(t0));
    tick();
    chk("lit_count1", 32'(c0), 32'd1);
    chk("lit_v_one_cycle", 32'(v0), 32'd0);
  endtask

  task automatic play_to(input int n);
    bit ok;
    int cyc;
    while (iss.size() < n) begin
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      wait_v(ok, cyc);
      if (!ok) break;
      iss.push_back(int'(t0));
      tick();
    end
  endtask

  task automatic fairness();
    logic [6:0] m;
    for (int g = 0; g + 7 <= iss.size(); g += 7) begin
      m = 7'd0;
      for (int j = 0; j < 7; j++) begin
        if (iss[g+j] >= 1 && iss[g+j] <= 7)
          m = m | (7'd1 << (iss[g+j] - 1));
      end
      chk("bag_perm", 32'(m), 32'h7F);
    end
  endtask

  task automatic handshake();
    logic [2:0] t_before, n_before;
    int vcnt;
    bit ok;
    int cyc;
    t_before = t0;
    n_before = n0;
    vcnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (v0) vcnt++;
    end
    chk("hs_no_v", 32'(vcnt), 32'd0);
    chk("hs_tile_stable", 32'(t0), 32'(t_before));
    done = 1'b1;
    tick();
    done = 1'b0;
    wait_v(ok, cyc);
    chk("hs_latency_ge2", 32'(cyc + 1 >= 2), 32'd1);
    chk("hs_tile_was_next", 32'(t0), 32'(n_before));
    tick();
    chk("hs_v_single", 32'(v0), 32'd0);
  endtask

  task automatic halt_test();
    int vcnt;
    logic [15:0] c_before;
    halt = 1'b1;
    done = 1'b1;
    tick();
    halt = 1'b0;
    done = 1'b0;
    chk("halt_busy", 32'(b0), 32'd0);
    c_before = c0;
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      done = 1'(i % 2);
      tick();
      if (v0) vcnt++;
    end
    done = 1'b0;
    chk("halt_no_v", 32'(vcnt), 32'd0);
    chk("halt_count_hold", 32'(c0), 32'(c_before));
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_count", 32'(c0), 32'd0);
    chk("restart_next", 32'(n0), 32'd0);
    chk("restart_busy", 32'(b0), 32'd1);
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      start = ($urandom_range(0, 19) == 0);
      halt  = ($urandom_range(0, 149) == 0);
      done  = ($urandom_range(0, 3) == 0);
      tick();
    end
    start = 1'b0;
    halt  = 1'b0;
    done  = 1'b0;
  endtask

  task automatic async_reset_test();
    halt = 1'b1;
    tick();
    halt  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("pre_reset_busy", 32'(b0), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("ar_v", 32'(v0), 32'd0);
    chk("ar_tile", 32'(t0), 32'd0);
    chk("ar_next", 32'(n0), 32'd0);
    chk("ar_count", 32'(c0), 32'd0);
    chk("ar_busy", 32'(b0), 32'd0);
    chk("ar_angle1", 32'(a1), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    halt  = 1'b0;
    done  = 1'b0;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    seed_start();
    play_to(70);
    chk("count_70", 32'(c0), 32'd70);
    fairness();
    handshake();
    halt_test();
    random_phase(4000);
    chk("forced_pick_seen", 32'(m_forced > 0), 32'd1);
    chk("angles_seen", 32'(ang_seen), 32'hF);
    async_reset_test();
    seed_start();
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
